// File: rtl/mul_csa_seq_pkg.sv
// Shared types and sizing helpers for the iterative carry-save multiplier.
package mul_seq_pkg;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULH   = 2'd1,
      MULHSU = 2'd2,
      MULHU  = 2'd3
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } mul_state_t;

   localparam int MUL_WIDTH = 32;

   // Step counter width; kept at least one bit so tiny widths still elaborate.
   function automatic int cnt_bits(input int width);
      return (width / 2 > 1) ? $clog2(width / 2) : 1;
   endfunction

   localparam int MUL_CNT_W = cnt_bits(MUL_WIDTH);

endpackage

// File: rtl/mul_csa_seq_if.sv
// Request/response bundle between a multiply requester and the sequencer.
interface mul_csa_seq_if #(parameter int WIDTH = 32);
   import mul_seq_pkg::*;

   logic             flush;
   logic             start;
   mul_op_t          op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_ack;
   logic             ready;
   logic             busy;
   logic             valid_out;
   logic [WIDTH-1:0] result;

   modport master (
      output flush, start, op, a, b, out_ack,
      input  ready, busy, valid_out, result
   );

   modport slave (
      input  flush, start, op, a, b, out_ack,
      output ready, busy, valid_out, result
   );

endinterface

// File: rtl/mul_csa_seq_csa42.sv
// Carry-save building blocks: a 3:2 adder and a 4:2 compressor made of two of them.
module mul_csa #(parameter int W = 64) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic [W-1:0] z,
   output logic [W-1:0] s,
   output logic [W-1:0] c
);
   logic [W-1:0] maj;

   assign s   = x ^ y ^ z;
   assign maj = (x & y) | (x & z) | (y & z);
   assign c   = maj << 1;

endmodule

// Folds two partial products into the running redundant sum/carry pair.
module mul_csa_42 #(parameter int W = 64) (
   input  logic [W-1:0] sum,
   input  logic [W-1:0] carry,
   input  logic [W-1:0] pp0,
   input  logic [W-1:0] pp1,
   output logic [W-1:0] sum_nx,
   output logic [W-1:0] carry_nx
);
   logic [W-1:0] s1;
   logic [W-1:0] c1;

   mul_csa #(.W(W)) u_csa0 (.x(sum), .y(carry), .z(pp0), .s(s1), .c(c1));
   mul_csa #(.W(W)) u_csa1 (.x(s1), .y(c1), .z(pp1), .s(sum_nx), .c(carry_nx));

endmodule

// File: rtl/mul_csa_seq.sv
// Radix-4 iterative multiplier: magnitudes in, two multiplier bits per cycle
// through a 4:2 compressor, then one carry-propagate add and sign fix-up.
module mul_csa_seq
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input logic             CLK,
   input logic             nRST,
   mul_csa_seq_if.slave    bus
);
   localparam int         CW   = cnt_bits(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

   mul_state_t         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] sum;
   logic [2*WIDTH-1:0] carry;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic               neg;
   logic               hi;
   logic [WIDTH-1:0]   result_q;
   logic               valid_q;

   logic               accept;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   ld_ma;
   logic [WIDTH-1:0]   ld_mb;
   logic [2*WIDTH-1:0] pp0;
   logic [2*WIDTH-1:0] pp1;
   logic [2*WIDTH-1:0] sum_nx;
   logic [2*WIDTH-1:0] carry_nx;
   logic [2*WIDTH-1:0] p_raw;
   logic [2*WIDTH-1:0] p_fix;

   assign bus.ready     = (state == IDLE) || (state == DONE && bus.out_ack);
   assign bus.busy      = (state == ACCUM) || (state == RESOLVE);
   assign bus.valid_out = valid_q;
   assign bus.result    = result_q;
   assign accept        = bus.start && bus.ready && !bus.flush;

   // Operand magnitudes and product sign for a request being accepted this cycle.
   always_comb begin
      a_neg = ((bus.op == MULH) || (bus.op == MULHSU)) && bus.a[WIDTH-1];
      b_neg = (bus.op == MULH) && bus.b[WIDTH-1];
      ld_ma = a_neg ? (~bus.a + 1'b1) : bus.a;
      ld_mb = b_neg ? (~bus.b + 1'b1) : bus.b;
   end

   // Partial products for the two multiplier bits currently at the bottom of mplier.
   always_comb begin
      pp0 = mplier[0] ? mcand : '0;
      pp1 = mplier[1] ? (mcand << 1) : '0;
   end

   mul_csa_42 #(.W(2 * WIDTH)) u_csa42 (
      .sum      (sum),
      .carry    (carry),
      .pp0      (pp0),
      .pp1      (pp1),
      .sum_nx   (sum_nx),
      .carry_nx (carry_nx)
   );

   // Carry-propagate the redundant pair and restore the sign of the product.
   always_comb begin
      p_raw = sum + carry;
      p_fix = neg ? (~p_raw + 1'b1) : p_raw;
   end

   // Sequencer: flush beats everything, an accept (IDLE or acked DONE) reloads,
   // otherwise the state advances.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         cnt      <= '0;
         sum      <= '0;
         carry    <= '0;
         mcand    <= '0;
         mplier   <= '0;
         neg      <= 1'b0;
         hi       <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (bus.flush) begin
         state   <= IDLE;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else if (accept) begin
         state   <= ACCUM;
         cnt     <= '0;
         sum     <= '0;
         carry   <= '0;
         mcand   <= {{WIDTH{1'b0}}, ld_ma};
         mplier  <= ld_mb;
         neg     <= a_neg ^ b_neg;
         hi      <= (bus.op != MUL);
         valid_q <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               sum    <= sum_nx;
               carry  <= carry_nx;
               mcand  <= mcand << 2;
               mplier <= mplier >> 2;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= RESOLVE;
               end
            end
            RESOLVE: begin
               result_q <= hi ? p_fix[2*WIDTH-1:WIDTH] : p_fix[WIDTH-1:0];
               valid_q  <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (bus.out_ack) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_csa_seq.sv
// Directed and randomized checks of mul_csa_seq against a plain-arithmetic product model.
module tb_mul_csa_seq;
   import mul_seq_pkg::*;

   localparam int W = 32;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mul_csa_seq_if #(.WIDTH(W)) bus ();

   mul_csa_seq #(.WIDTH(W)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   // Free-running clock, 10 time units per period.
   always #5 CLK = ~CLK;

   // Reference product computed with full-width arithmetic on extended operands.
   function automatic logic [W-1:0] refMul(input mul_op_t op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      logic [2*W-1:0] sa, sb, ua, ub, p;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      ua = {{W{1'b0}}, a};
      ub = {{W{1'b0}}, b};
      case (op)
         MULH:    p = sa * sb;
         MULHSU:  p = sa * ub;
         default: p = ua * ub;
      endcase
      return (op == MUL) ? p[W-1:0] : p[2*W-1:W];
   endfunction

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Presents one request and returns just after the edge that accepts it.
   task automatic applyStimulus(input mul_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      tick();
      bus.start   = 1'b0;
      bus.out_ack = 1'b0;
   endtask

   task automatic waitResult(input string tag, input logic [W-1:0] exp);
      int n;
      n = 0;
      while (!bus.valid_out && n < 40) begin
         tick();
         n++;
      end
      checkOutput({tag, " latency"}, W'(n), W'(17));
      checkOutput({tag, " result"}, bus.result, exp);
   endtask

   task automatic ackResult(input string tag);
      bus.out_ack = 1'b1;
      tick();
      bus.out_ack = 1'b0;
      checkOutput({tag, " valid after ack"}, W'(bus.valid_out), W'(0));
      checkOutput({tag, " ready after ack"}, W'(bus.ready), W'(1));
   endtask

   task automatic runOp(input string tag, input mul_op_t op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
      applyStimulus(op, a, b);
      checkOutput({tag, " busy"}, W'(bus.busy), W'(1));
      waitResult(tag, exp);
      ackResult(tag);
   endtask

   initial begin
      logic       sawValid;
      mul_op_t    rop;
      logic [W-1:0] ra, rb;

      bus.flush   = 1'b0;
      bus.start   = 1'b0;
      bus.op      = MUL;
      bus.a       = '0;
      bus.b       = '0;
      bus.out_ack = 1'b0;

      // Reset values.
      tick();
      tick();
      checkOutput("reset ready", W'(bus.ready), W'(1));
      checkOutput("reset busy", W'(bus.busy), W'(0));
      checkOutput("reset valid", W'(bus.valid_out), W'(0));
      checkOutput("reset result", bus.result, '0);
      nRST = 1'b1;
      tick();

      // Directed cases.
      runOp("mul 7x6", MUL, 32'd7, 32'd6, 32'h0000002A);
      runOp("mulhu ff", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      runOp("mul ff", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
      runOp("mulh min", MULH, 32'h80000000, 32'h80000000, 32'h40000000);
      runOp("mulh -1x5", MULH, 32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFF);
      runOp("mulhsu -2x3", MULHSU, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
      runOp("mulhsu 2xff", MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001);

      // Flush during ACCUM, with a competing start in the same cycle.
      applyStimulus(MUL, 32'd100, 32'd200);
      repeat (4) tick();
      bus.flush = 1'b1;
      bus.start = 1'b1;
      bus.a     = 32'd11;
      bus.b     = 32'd13;
      tick();
      bus.flush = 1'b0;
      bus.start = 1'b0;
      checkOutput("flush ready", W'(bus.ready), W'(1));
      checkOutput("flush busy", W'(bus.busy), W'(0));
      checkOutput("flush valid", W'(bus.valid_out), W'(0));
      sawValid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.valid_out) sawValid = 1'b1;
      end
      checkOutput("flush no valid", W'(sawValid), W'(0));
      runOp("mul 3x4", MUL, 32'd3, 32'd4, 32'h0000000C);

      // Result held without ack, then ack plus back-to-back start.
      applyStimulus(MUL, 32'd5, 32'd7);
      waitResult("hold", 32'd35);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("hold valid", W'(bus.valid_out), W'(1));
         checkOutput("hold result", bus.result, 32'd35);
      end
      bus.out_ack = 1'b1;
      applyStimulus(MUL, 32'd9, 32'd9);
      checkOutput("b2b busy", W'(bus.busy), W'(1));
      checkOutput("b2b valid", W'(bus.valid_out), W'(0));
      waitResult("b2b", 32'h00000051);

      // Async reset mid-ACCUM: outputs return to reset values without a clock edge.
      bus.out_ack = 1'b1;
      applyStimulus(MULHU, 32'hDEADBEEF, 32'h12345678);
      repeat (3) tick();
      #2;
      nRST = 1'b0;
      #1;
      checkOutput("async ready", W'(bus.ready), W'(1));
      checkOutput("async busy", W'(bus.busy), W'(0));
      checkOutput("async valid", W'(bus.valid_out), W'(0));
      checkOutput("async result", bus.result, '0);
      tick();
      nRST = 1'b1;
      tick();

      // Randomized operations against the reference model, salted with corner operands.
      for (int i = 0; i < 24; i++) begin
         rop = mul_op_t'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: ra = 32'h80000000;
            1: rb = 32'h80000000;
            2: ra = 32'hFFFFFFFF;
            3: rb = 32'h00000000;
            default: ;
         endcase
         runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, refMul(rop, ra, rb));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_csa_seq.md
# mul_csa_seq

Iterative carry-save multiplier sequencer for the rv32v vector multiply lane. It accepts one WIDTH×WIDTH multiply per request and retires two multiplier bits per cycle, accumulating partial products in redundant sum/carry form through carry-save adders. A single carry-propagate add and sign fix-up then resolve the product, and the block returns the low or high WIDTH bits under a valid/ack handshake.

## Interface
- WIDTH, 32, operand/result width; must be even.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- flush  in  1  abort any in-flight operation.
- start  in  1  request valid; operands sampled when start && ready.
- op  in  2  mul_op_t: MUL(0) low half; MULH(1) s×s high; MULHSU(2) s×u high; MULHU(3) u×u high.
- a  in  WIDTH  multiplicand (rs1/vs2 element).
- b  in  WIDTH  multiplier (rs2/vs1 element).
- ready  out  1  can accept a request.
- busy  out  1  state is ACCUM or RESOLVE.
- valid_out  out  1  result valid; held until acknowledged.
- result  out  WIDTH  selected product half.
- out_ack  in  1  consumer takes result; meaningful only while valid_out.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE: ready=1. On start, capture: ma=|a| if a is signed (MULH, MULHSU) and a[WIDTH-1]=1, else a; mb=|b| if b is signed (MULH only) and negative, else b; neg = effective sign a XOR effective sign b; hi = (op!=MUL). Clear sum/carry (2·WIDTH each) and cnt. Go to ACCUM.
- Magnitudes are WIDTH-bit unsigned; |−2^(WIDTH−1)| = 2^(WIDTH−1) fits. All accumulation is mod 2^(2·WIDTH).
- ACCUM, step i (cnt=i, 0..WIDTH/2−1):
  - pp0 = mb[2i] ? ma<<2i : 0
  - pp1 = mb[2i+1] ? ma<<(2i+1) : 0
  - {sum,carry} ← csa(csa(sum,carry,pp0), pp1), where each csa yields a sum and carry<<1 with the carry MSB dropped.
  - When cnt = WIDTH/2−1, go to RESOLVE.
- RESOLVE: p = sum+carry (2·WIDTH); if neg, p = −p. Register result = hi ? p[2W−1:W] : p[W−1:0]. Go to DONE.
- DONE: valid_out=1 and result stable. out_ack → IDLE.
- ready = (state==IDLE) || (state==DONE && out_ack). A start in that DONE cycle is accepted directly into ACCUM (back-to-back operation, no bubble).
- flush has priority over everything. Any state → IDLE at the next edge, and valid_out drops. A start in the same cycle is ignored. The result register is not cleared.
- start while not ready: ignored; the requester holds it.

## Timing
- Reset (async, nRST=0): state=IDLE, cnt=0, sum=carry=0, result=0, valid_out=0, busy=0, ready=1.
- Accept at edge E0. ACCUM occupies WIDTH/2 cycles. result is registered at edge E0+WIDTH/2+1, and valid_out is high from that edge. Latency is 17 edges for WIDTH=32, fixed and data-independent.
- Throughput: one operation per WIDTH/2+2 cycles with immediate ack, because of the back-to-back accept.
- Reset asserted mid-operation: the output state above applies immediately. No partial result ever appears.

## Structure
- mul_seq_pkg:
  - mul_op_t enum (2 bits).
  - mul_state_t enum (IDLE, ACCUM, RESOLVE, DONE).
  - localparam helper for the counter width, $clog2(WIDTH/2).
- Sub-module mul_csa_42: 4:2 compressor at 2·WIDTH built from two chained mul_csa instances (sum, carry, pp0, pp1 → sum', carry'). It is purely combinational and instantiated once.
- The final add, negate, and half select are inline in the sequencer.

## Test plan
- MUL a=7, b=6 → result=0x0000002A, valid_out exactly 17 edges after accept.
- MULHU a=b=0xFFFFFFFF → result=0xFFFFFFFE; MUL on the same operands → 0x00000001.
- MULH a=b=0x80000000 → result=0x40000000; MULH a=0xFFFFFFFF (−1), b=0x00000005 → result=0xFFFFFFFF.
- MULHSU a=0xFFFFFFFE (−2), b=0x00000003 → result=0xFFFFFFFF; MULHSU a=2, b=0xFFFFFFFF (unsigned) → result=0x00000001.
- Flush at cycle 5 of ACCUM → valid_out never rises, ready=1 at the next edge. A new MUL 3×4 → 0x0000000C with normal latency.
- Hold out_ack low for 10 cycles → valid_out and result stay stable. Then out_ack with start (MUL 9×9) in the same cycle → accepted with no idle cycle, result 0x00000051. Async reset pulse mid-ACCUM → all outputs at reset values immediately.
